// File: rtl/scc_pkg.sv
// Shared types for the SCC command master: command word, FSM states, register map anchors.
package scc_pkg;

   typedef struct packed {
      logic       write;
      logic       cart;
      logic [7:0] addr;
      logic [7:0] data;
   } scc_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACTIVE,
      ST_RECOVER
   } scc_mst_state_t;

   localparam logic [7:0] SCC_WAVE_BASE = 8'h80;

endpackage

// File: rtl/scc_cmd_fifo.sv
// Synchronous command FIFO, zero-latency head (pop_dat valid while !empty).
// Pushes while full are dropped; the caller gates on ~full.
module scc_cmd_fifo
   import scc_pkg::*;
#(
   parameter int DEPTH = 8
)(
   input  logic     clk,
   input  logic     reset,
   input  logic     push,
   input  scc_cmd_t push_dat,
   input  logic     pop,
   output scc_cmd_t pop_dat,
   output logic     full,
   output logic     empty
);
   localparam int AW = $clog2(DEPTH);

   scc_cmd_t      mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Extra wrap bit tells full from empty when the index bits match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   assign pop_dat = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
   end

endmodule

// File: rtl/scc_cmd_master.sv
// SCC bus initiator: each queued command becomes one clk_en-timed register cycle; cmd_ready = ~fifo_full.
// Read data return is built only with SCC_CMD_MASTER_READBACK_EN; otherwise reads are dropped at pop.
module scc_cmd_master
   import scc_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int HOLD_TICKS = 2
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       clk_en,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic       cmd_cart,
   input  logic [7:0] cmd_addr,
   input  logic [7:0] cmd_data,
   output logic       cs,
   output logic       cart_num,
   output logic       cpu_wr,
   output logic       cpu_mreq,
   output logic [7:0] cpu_addr,
   output logic [7:0] din,
   input  logic [7:0] scc_dout,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy
);
`ifdef SCC_CMD_MASTER_READBACK_EN
   localparam bit READBACK = 1'b1;
`else
   localparam bit READBACK = 1'b0;
`endif

   scc_cmd_t       push_dat;
   scc_cmd_t       head;
   logic           full;
   logic           empty;
   logic           pop;
   logic           cmd_wr_q;
   logic [3:0]     tick_cnt;
   scc_mst_state_t state;

   assign push_dat  = '{write: cmd_write, cart: cmd_cart, addr: cmd_addr, data: cmd_data};
   assign cmd_ready = ~full;
   assign pop       = (state == ST_IDLE) && clk_en && !empty;
   assign busy      = (state != ST_IDLE) || !empty;

   scc_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (cmd_valid),
      .push_dat (push_dat),
      .pop      (pop),
      .pop_dat  (head),
      .full     (full),
      .empty    (empty)
   );

   // IDLE also waits for clk_en so a stalled clk_en freezes the queue head in the FIFO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         tick_cnt  <= '0;
         cmd_wr_q  <= 1'b0;
         cs        <= 1'b0;
         cpu_mreq  <= 1'b0;
         cpu_wr    <= 1'b0;
         cart_num  <= 1'b0;
         cpu_addr  <= '0;
         din       <= '0;
`ifdef SCC_CMD_MASTER_READBACK_EN
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
`endif
      end else begin
`ifdef SCC_CMD_MASTER_READBACK_EN
         rsp_valid <= 1'b0;
`endif
         if (clk_en) begin
            case (state)
               ST_IDLE: begin
                  if (!empty && (head.write || READBACK)) begin
                     cmd_wr_q <= head.write;
                     cart_num <= head.cart;
                     cpu_addr <= head.addr;
                     din      <= head.data;
                     state    <= ST_SETUP;
                  end
               end
               ST_SETUP: begin
                  cs       <= 1'b1;
                  cpu_mreq <= 1'b1;
                  cpu_wr   <= cmd_wr_q;
                  tick_cnt <= 4'(HOLD_TICKS - 1);
                  state    <= ST_ACTIVE;
               end
               ST_ACTIVE: begin
                  if (tick_cnt == 4'd0) begin
                     cs       <= 1'b0;
                     cpu_mreq <= 1'b0;
                     cpu_wr   <= 1'b0;
                     state    <= ST_RECOVER;
`ifdef SCC_CMD_MASTER_READBACK_EN
                     if (!cmd_wr_q) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= scc_dout;
                     end
`endif
                  end else begin
                     tick_cnt <= tick_cnt - 4'd1;
                  end
               end
               ST_RECOVER: state <= ST_IDLE;
               default:    state <= ST_IDLE;
            endcase
         end
      end
   end

`ifndef SCC_CMD_MASTER_READBACK_EN
   logic unused_scc_dout;
   assign unused_scc_dout = ^scc_dout;
   assign rsp_valid       = 1'b0;
   assign rsp_data        = '0;
`endif

endmodule
